dma_copy_engine: RTL and testbench
==================================

# dma_copy_engine

Word-granular memory-to-memory DMA engine filling the DMA master slot of the crossbar. Its responder (slave) port sits on the peripheral bus and exposes four control/status registers; its initiator (master) port issues single-word read-then-write transfers through the crossbar to any memory-mapped target. One transfer is in flight at a time; burst length is always 1.

## Interface
- NUM_PERIPH_SEL_BITS, 16, number of upper word-address bits compared for slave select.
- PERIPH_SEL_VAL, 0, value that `i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS]` must equal to select this block.
- LEN_BITS, 16, width of the transfer word counter.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_nReset  in  1  synchronous, active-low reset.
- i_AV_Addr  in  30  slave word address; register offset = `[1:0]`.
- i_AV_ByteEn  in  4  slave byte enables; only writes with all four set update registers.
- i_AV_Read  in  1  slave read strobe.
- o_AV_ReadData  out  32  slave read data; 0 when not selected (bus is OR-combined).
- i_AV_Write  in  1  slave write strobe.
- i_AV_WriteData  in  32  slave write data.
- o_AV_WaitRequest  out  1  slave stall; 0 when not selected.
- i_AV_BurstCount  in  8  ignored.
- o_AVM_Addr  out  30  master word address.
- o_AVM_ByteEn  out  4  always 4'b1111.
- o_AVM_Read  out  1  master read strobe.
- i_AVM_ReadData  in  32  master read data.
- o_AVM_Write  out  1  master write strobe.
- o_AVM_WriteData  out  32  master write data.
- i_AVM_WaitRequest  in  1  master stall.
- o_AVM_BurstCount  out  8  always 8'd1.
- o_Irq  out  1  only with DMA_IRQ_EN; see Configuration.

## Operation
- Registers (offset): 0 SRC[29:0], 1 DST[29:0], 2 LEN[LEN_BITS-1:0], 3 CTRL. Unused bits read 0.
- CTRL write: bit0 START, bit3 ABORT, bit2 write-1-clears DONE, bit4 IE (with DMA_IRQ_EN). CTRL read: bit1 BUSY, bit2 DONE, bit4 IE.
- SRC/DST/LEN read back live progress values.
- Writes to SRC/DST/LEN while BUSY are ignored; START while BUSY is ignored.
- FSM states: IDLE, RD, WR.
  - IDLE: START with LEN≠0 → RD, BUSY=1, DONE cleared. START with LEN=0 → stay IDLE, DONE=1, no bus activity.
  - RD: o_AVM_Read=1, o_AVM_Addr=SRC. When i_AVM_WaitRequest=0, latch i_AVM_ReadData → WR.
  - WR: o_AVM_Write=1, o_AVM_Addr=DST, data=latched word. When i_AVM_WaitRequest=0: SRC+=1, DST+=1 (mod 2^30), LEN-=1; LEN reaches 0 → IDLE, DONE=1; else → RD.
- ABORT: latched as pending; the in-flight Read/Write is held until accepted (strobes never drop while WaitRequest=1), then → IDLE, BUSY=0, DONE unchanged. An aborted write's increments still apply. ABORT in IDLE has no effect.
- Simultaneous START and ABORT in IDLE: START wins.
- DONE set and DONE-clear write in the same cycle: set wins.

## Timing
- Reset values: all registers 0, state IDLE, o_AV_ReadData=0, o_AV_WaitRequest=0, o_AVM_Read=0, o_AVM_Write=0, o_AVM_Addr=0, o_AVM_WriteData=0, o_Irq=0.
- Reset is synchronous and overrides everything, including mid-transfer: the master strobes are 0 in the cycle after the reset edge.
- Slave read: the cycle a selected read is seen asserts WaitRequest=1 and registers the data. The next cycle has WaitRequest=0 with ReadData valid. One wait state.
- Slave write: zero wait states; takes effect at the edge where Write and select are high.
- Master: RD asserted the cycle after START is accepted. Each word costs at least 2 cycles (RD+WR) with zero-wait targets. N words take at least 2N cycles from first Read to DONE.
- All master outputs are registered.

## Configuration
- DMA_IRQ_EN defined: o_Irq port and CTRL.IE exist. o_Irq = DONE & IE, registered (1-cycle delay from DONE).
- DMA_IRQ_EN undefined: no o_Irq port, IE not stored, CTRL bit4 reads 0.

## Test plan
- Copy: SRC=0x100, DST=0x200, LEN=4, START with zero-wait memory → 4 read/write pairs at 0x100..0x103 → 0x200..0x203; data matches; DONE=1 and LEN=0 after 8 bus cycles.
- Stall: target holds WaitRequest for 3 cycles on each access → strobes and address stable throughout; copy correct.
- LEN=0 START → no master strobe, DONE=1 next cycle; writing CTRL=0x4 → DONE=0.
- ABORT during a stalled WR of word 2 of 5 → write completes, IDLE, LEN=3, SRC/DST advanced by 2.
- Wrap: SRC=0x3FFFFFFF, LEN=2 → second read at 0x00000000. Writes to SRC while BUSY ignored. Unselected slave reads return 0 and WaitRequest=0.
- With DMA_IRQ_EN: IE=1, LEN=1 copy → o_Irq rises one cycle after DONE and falls after the DONE clear. Reset asserted mid-RD → Read=0 the next cycle and all registers read 0.

Source files
------------

// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Word-granular memory-to-memory DMA engine. A peripheral-bus responder
//   port exposes SRC/DST/LEN/CTRL registers; an initiator port performs
//   single-word read-then-write copies (burst length 1, one transfer in
//   flight).
//
//   Optional feature: define DMA_IRQ_EN to add CTRL.IE and the o_Irq port.
//
// Ports
//   i_Clk, i_nReset            clock, synchronous active-low reset
//   i_AV_*  / o_AV_*           responder port (word address, offset = [1:0])
//   o_AVM_* / i_AVM_*          initiator port (single-word read / write)
//   o_Irq                      DONE & IE, registered (DMA_IRQ_EN only)

module dma_copy_engine #(
    parameter int unsigned NUM_PERIPH_SEL_BITS = 16,
    parameter int unsigned PERIPH_SEL_VAL      = 0,
    parameter int unsigned LEN_BITS            = 16
) (
    input  logic        i_Clk,
    input  logic        i_nReset,

    input  logic [29:0] i_AV_Addr,
    input  logic [3:0]  i_AV_ByteEn,
    input  logic        i_AV_Read,
    output logic [31:0] o_AV_ReadData,
    input  logic        i_AV_Write,
    input  logic [31:0] i_AV_WriteData,
    output logic        o_AV_WaitRequest,
    input  logic [7:0]  i_AV_BurstCount,

    output logic [29:0] o_AVM_Addr,
    output logic [3:0]  o_AVM_ByteEn,
    output logic        o_AVM_Read,
    input  logic [31:0] i_AVM_ReadData,
    output logic        o_AVM_Write,
    output logic [31:0] o_AVM_WriteData,
    input  logic        i_AVM_WaitRequest,
    output logic [7:0]  o_AVM_BurstCount
`ifdef DMA_IRQ_EN
    ,
    output logic        o_Irq
`endif
);

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] OFS_SRC  = 2'd0;
    localparam logic [1:0] OFS_DST  = 2'd1;
    localparam logic [1:0] OFS_LEN  = 2'd2;
    localparam logic [1:0] OFS_CTRL = 2'd3;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_DCLR  = 2;
    localparam int unsigned CTRL_ABORT = 3;
    localparam int unsigned CTRL_IE    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   dst;
    logic [LEN_BITS-1:0] len;
    logic                done;
    logic                abort_pend;
    logic                rd_pending;
    logic                ie;

    logic                sel;
    logic [1:0]          ofs;
    logic                reg_wr;
    logic                ctrl_wr;
    logic                rd_accept;
    logic                busy;
    logic                start_req;
    logic                abort_req;
    logic                done_clr_req;
    logic                abort_now;
    logic [DATA_W-1:0]   rd_mux;

    // Responder decode
    assign sel          = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS]
                           == NUM_PERIPH_SEL_BITS'(PERIPH_SEL_VAL));
    assign ofs          = i_AV_Addr[1:0];
    assign reg_wr       = sel & i_AV_Write & (i_AV_ByteEn == 4'hF);
    assign ctrl_wr      = reg_wr & (ofs == OFS_CTRL);
    assign busy         = (state != ST_IDLE);
    assign start_req    = ctrl_wr & i_AV_WriteData[CTRL_START];
    assign abort_req    = ctrl_wr & i_AV_WriteData[CTRL_ABORT];
    assign done_clr_req = ctrl_wr & i_AV_WriteData[CTRL_DCLR];
    assign abort_now    = abort_pend | abort_req;

    // A read is accepted on its first cycle (stalled), answered on the next
    assign rd_accept        = sel & i_AV_Read & ~rd_pending;
    assign o_AV_WaitRequest = rd_accept;

    assign o_AVM_ByteEn     = 4'hF;
    assign o_AVM_BurstCount = 8'd1;

    // Register read-back multiplexer
    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_SRC:  rd_mux = {2'b00, src};
            OFS_DST:  rd_mux = {2'b00, dst};
            OFS_LEN:  rd_mux = DATA_W'(len);
            OFS_CTRL: rd_mux = {27'd0, ie, 1'b0, done, busy, 1'b0};
            default:  rd_mux = '0;
        endcase
    end

    // Responder read path, register file and copy FSM
    always_ff @(posedge i_Clk) begin
        if (!i_nReset) begin
            state           <= ST_IDLE;
            src             <= '0;
            dst             <= '0;
            len             <= '0;
            done            <= 1'b0;
            abort_pend      <= 1'b0;
            rd_pending      <= 1'b0;
            o_AV_ReadData   <= '0;
            o_AVM_Addr      <= '0;
            o_AVM_Read      <= 1'b0;
            o_AVM_Write     <= 1'b0;
            o_AVM_WriteData <= '0;
        end else begin
            rd_pending    <= rd_accept;
            o_AV_ReadData <= rd_accept ? rd_mux : '0;

            // Address/length registers are frozen while a copy runs
            if (reg_wr && !busy) begin
                case (ofs)
                    OFS_SRC: src <= i_AV_WriteData[ADDR_W-1:0];
                    OFS_DST: dst <= i_AV_WriteData[ADDR_W-1:0];
                    OFS_LEN: len <= i_AV_WriteData[LEN_BITS-1:0];
                    default: ;
                endcase
            end

            // Clear first; any set below in the same cycle takes priority
            if (done_clr_req) begin
                done <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (start_req) begin
                        if (len != '0) begin
                            state      <= ST_RD;
                            o_AVM_Read <= 1'b1;
                            o_AVM_Addr <= src;
                            done       <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    if (abort_req) begin
                        abort_pend <= 1'b1;
                    end
                    if (!i_AVM_WaitRequest) begin
                        o_AVM_Read <= 1'b0;
                        if (abort_now) begin
                            state      <= ST_IDLE;
                            abort_pend <= 1'b0;
                        end else begin
                            state           <= ST_WR;
                            o_AVM_Write     <= 1'b1;
                            o_AVM_Addr      <= dst;
                            o_AVM_WriteData <= i_AVM_ReadData;
                        end
                    end
                end

                ST_WR: begin
                    if (abort_req) begin
                        abort_pend <= 1'b1;
                    end
                    if (!i_AVM_WaitRequest) begin
                        // A completed write always advances the pointers
                        o_AVM_Write <= 1'b0;
                        src         <= src + ADDR_W'(1);
                        dst         <= dst + ADDR_W'(1);
                        len         <= len - LEN_BITS'(1);
                        if (len == LEN_BITS'(1)) begin
                            state      <= ST_IDLE;
                            done       <= 1'b1;
                            abort_pend <= 1'b0;
                        end else if (abort_now) begin
                            state      <= ST_IDLE;
                            abort_pend <= 1'b0;
                        end else begin
                            state      <= ST_RD;
                            o_AVM_Read <= 1'b1;
                            o_AVM_Addr <= src + ADDR_W'(1);
                        end
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    o_AVM_Read  <= 1'b0;
                    o_AVM_Write <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMA_IRQ_EN
    // Interrupt enable and registered interrupt output
    always_ff @(posedge i_Clk) begin
        if (!i_nReset) begin
            ie    <= 1'b0;
            o_Irq <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ie <= i_AV_WriteData[CTRL_IE];
            end
            o_Irq <= done & ie;
        end
    end
`else
    assign ie = 1'b0;
`endif

    // Inputs with no function in this block
    logic unused_inputs;
    assign unused_inputs = ^{i_AV_BurstCount,
                             i_AV_WriteData[DATA_W-1:ADDR_W],
                             i_AV_Addr[29-NUM_PERIPH_SEL_BITS:2]};

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine
//   Directed bench for dma_copy_engine with a small word memory acting as
//   the crossbar target (programmable wait states).

module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] av_addr;
    logic [3:0]  av_be;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_wdata;
    logic [7:0]  av_burst;
    logic [31:0] av_rdata;
    logic        av_wait;
    logic [29:0] avm_addr;
    logic [3:0]  avm_be;
    logic        avm_read;
    logic [31:0] avm_rdata;
    logic        avm_write;
    logic [31:0] avm_wdata;
    logic        avm_wait;
    logic [7:0]  avm_burst;
`ifdef DMA_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int errors  = 0;

    // Target memory model
    logic [31:0] mem [0:4095];
    int          stall = 0;
    int          wcnt = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          stall_err = 0;
    logic        hold_chk = 1'b0;
    logic [63:0] hold_snap = '0;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .i_Clk            (clk),
        .i_nReset         (rst_n),
        .i_AV_Addr        (av_addr),
        .i_AV_ByteEn      (av_be),
        .i_AV_Read        (av_read),
        .o_AV_ReadData    (av_rdata),
        .i_AV_Write       (av_write),
        .i_AV_WriteData   (av_wdata),
        .o_AV_WaitRequest (av_wait),
        .i_AV_BurstCount  (av_burst),
        .o_AVM_Addr       (avm_addr),
        .o_AVM_ByteEn     (avm_be),
        .o_AVM_Read       (avm_read),
        .i_AVM_ReadData   (avm_rdata),
        .o_AVM_Write      (avm_write),
        .o_AVM_WriteData  (avm_wdata),
        .i_AVM_WaitRequest(avm_wait),
        .o_AVM_BurstCount (avm_burst)
`ifdef DMA_IRQ_EN
        ,
        .o_Irq            (irq)
`endif
    );

    assign avm_wait  = (avm_read || avm_write) && (wcnt != stall);
    assign avm_rdata = mem[avm_addr[11:0]];

    always @(posedge clk) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else if (avm_read || avm_write) begin
            if (avm_wait) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
                if (avm_write) begin
                    mem[avm_addr[11:0]] = avm_wdata;
                    n_wr = n_wr + 1;
                end else begin
                    n_rd = n_rd + 1;
                end
            end
        end
        // Strobes, address and data must not move while stalled
        if (rst_n && hold_chk &&
            ({avm_read, avm_write, avm_addr, avm_wdata} !== hold_snap))
            stall_err = stall_err + 1;
        hold_chk  <= rst_n && (avm_read || avm_write) && avm_wait;
        hold_snap <= {avm_read, avm_write, avm_addr, avm_wdata};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        av_addr  = a;
        av_wdata = d;
        av_be    = be;
        av_write = 1'b1;
        @(negedge clk);
        av_write = 1'b0;
        av_be    = 4'h0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d,
                            output logic w1, output logic w2);
        @(negedge clk);
        av_addr = a;
        av_read = 1'b1;
        #1 w1 = av_wait;
        @(negedge clk);
        w2 = av_wait;
        d  = av_rdata;
        @(negedge clk);
        av_read = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] ofs, input logic [31:0] d);
        bus_write({28'd0, ofs}, d, 4'hF);
    endtask

    task automatic check_reg(input string tag, input logic [1:0] ofs, input logic [31:0] exp);
        logic [31:0] d;
        logic        w1;
        logic        w2;
        bus_read({28'd0, ofs}, d, w1, w2);
        check(tag, d, exp);
    endtask

    task automatic wait_wr(input string tag, input int target);
        for (int i = 0; i < 400 && n_wr < target; i++) @(negedge clk);
        check(tag, 32'(n_wr), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (i < 400 && (avm_read || avm_write)) begin
            @(negedge clk);
            i++;
        end
        check(tag, {30'd0, avm_read, avm_write}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        w1;
        logic        w2;
        int          rd0;
        int          wr0;

        rst_n    = 1'b0;
        av_addr  = '0;
        av_be    = '0;
        av_read  = 1'b0;
        av_write = 1'b0;
        av_wdata = '0;
        av_burst = 8'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 32'hC0DE_0000 + 32'(i);
        mem[12'hFFF] = 32'h5A5A_0FFF;
        mem[12'h000] = 32'hA5A5_0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_avm_read", {31'd0, avm_read}, 32'd0);
        check("rst_avm_write", {31'd0, avm_write}, 32'd0);
        check("rst_avm_addr", {2'b0, avm_addr}, 32'd0);
        check("rst_avm_wdata", avm_wdata, 32'd0);
        check("rst_av_rdata", av_rdata, 32'd0);
        check("rst_av_wait", {31'd0, av_wait}, 32'd0);
        check("const_byteen", {28'd0, avm_be}, 32'hF);
        check("const_burst", {24'd0, avm_burst}, 32'd1);
        rst_n = 1'b1;

        bus_read(30'd0, d, w1, w2);
        check("rd_wait_first", {31'd0, w1}, 32'd1);
        check("rd_wait_second", {31'd0, w2}, 32'd0);
        check("rst_src", d, 32'd0);
        check_reg("rst_dst", 2'd1, 32'd0);
        check_reg("rst_len", 2'd2, 32'd0);
        check_reg("rst_ctrl", 2'd3, 32'd0);

        // Zero-wait copy of 4 words
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'h200);
        reg_wr(2'd2, 32'd4);
        check_reg("len_wr", 2'd2, 32'd4);
        reg_wr(2'd3, 32'h1);
        check("copy_first_rd", {avm_read, avm_write, avm_addr}, {2'b10, 30'h100});
        repeat (7) @(negedge clk);
        check("copy_last_wr", {avm_read, avm_write, avm_addr}, {2'b01, 30'h203});
        check("copy_last_wdata", avm_wdata, 32'hC0DE_0003);
        @(negedge clk);
        check("copy_idle_at_8", {30'd0, avm_read, avm_write}, 32'd0);
        check("copy_counts", 32'(n_rd * 16 + n_wr), 32'(4 * 16 + 4));
        for (int i = 0; i < 4; i++)
            check("copy_data", mem[12'h200 + i], 32'hC0DE_0000 + 32'(i));
        check_reg("copy_ctrl", 2'd3, 32'h4);
        check_reg("copy_len", 2'd2, 32'd0);
        check_reg("copy_src", 2'd0, 32'h104);
        check_reg("copy_dst", 2'd1, 32'h204);

        // Three wait states per access; SRC write while busy is dropped
        stall = 3;
        wr0 = n_wr;
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'h210);
        reg_wr(2'd2, 32'd2);
        reg_wr(2'd3, 32'h1);
        check_reg("stall_busy", 2'd3, 32'h2);
        reg_wr(2'd0, 32'h555);
        wait_wr("stall_wr_count", wr0 + 2);
        @(negedge clk);
        check("stall_mem0", mem[12'h210], 32'hC0DE_0000);
        check("stall_mem1", mem[12'h211], 32'hC0DE_0001);
        check("stall_stable", 32'(stall_err), 32'd0);
        check_reg("stall_src_ignored", 2'd0, 32'h102);
        check_reg("stall_ctrl", 2'd3, 32'h4);

        // LEN=0 start and DONE clear priority
        stall = 0;
        rd0 = n_rd;
        reg_wr(2'd3, 32'h4);
        check_reg("dclr", 2'd3, 32'h0);
        reg_wr(2'd3, 32'h1);
        check("len0_no_read", {31'd0, avm_read}, 32'd0);
        check_reg("len0_done", 2'd3, 32'h4);
        check("len0_no_bus", 32'(n_rd), 32'(rd0));
        reg_wr(2'd3, 32'h4);
        check_reg("len0_dclr", 2'd3, 32'h0);
        reg_wr(2'd3, 32'h5);
        check_reg("set_beats_clr", 2'd3, 32'h4);
        reg_wr(2'd3, 32'h4);

        // ABORT during stalled write of word 2 of 5
        stall = 3;
        rd0 = n_rd;
        wr0 = n_wr;
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'h220);
        reg_wr(2'd2, 32'd5);
        reg_wr(2'd3, 32'h1);
        wait_wr("abort_word1", wr0 + 1);
        for (int i = 0; i < 100 && !avm_write; i++) @(negedge clk);
        reg_wr(2'd3, 32'h8);
        check("abort_wr_held", {avm_write, avm_addr}, {1'b1, 30'h221});
        wait_idle("abort_idle");
        repeat (4) @(negedge clk);
        check("abort_wr_count", 32'(n_wr - wr0), 32'd2);
        check("abort_rd_count", 32'(n_rd - rd0), 32'd2);
        check("abort_mem1", mem[12'h221], 32'hC0DE_0001);
        check_reg("abort_len", 2'd2, 32'd3);
        check_reg("abort_src", 2'd0, 32'h102);
        check_reg("abort_dst", 2'd1, 32'h222);
        check_reg("abort_ctrl", 2'd3, 32'h0);

        // START and ABORT together in IDLE: START wins; ABORT alone is inert
        stall = 0;
        reg_wr(2'd3, 32'h8);
        check_reg("abort_idle_ctrl", 2'd3, 32'h0);
        reg_wr(2'd0, 32'h105);
        reg_wr(2'd1, 32'h230);
        reg_wr(2'd2, 32'd1);
        reg_wr(2'd3, 32'h9);
        wait_idle("sa_idle");
        check("sa_mem", mem[12'h230], 32'hC0DE_0005);
        check_reg("sa_ctrl", 2'd3, 32'h4);
        check_reg("sa_len", 2'd2, 32'd0);

        // Source address wraps modulo 2^30
        reg_wr(2'd0, 32'h3FFF_FFFF);
        reg_wr(2'd1, 32'h300);
        reg_wr(2'd2, 32'd2);
        reg_wr(2'd3, 32'h1);
        check("wrap_rd0", {avm_read, avm_addr}, {1'b1, 30'h3FFF_FFFF});
        repeat (2) @(negedge clk);
        check("wrap_rd1", {avm_read, avm_addr}, {1'b1, 30'h0});
        wait_idle("wrap_idle");
        check("wrap_mem0", mem[12'h300], 32'h5A5A_0FFF);
        check("wrap_mem1", mem[12'h301], 32'hA5A5_0000);
        check_reg("wrap_src", 2'd0, 32'h1);

        // Unselected accesses and partial byte enables
        @(negedge clk);
        av_addr = 30'h0001_0000;
        av_read = 1'b1;
        #1 check("unsel_wait", {31'd0, av_wait}, 32'd0);
        @(negedge clk);
        check("unsel_rdata", av_rdata, 32'd0);
        av_read = 1'b0;
        bus_write(30'h0001_0000, 32'h777, 4'hF);
        bus_write(30'h0, 32'h777, 4'h3);
        check_reg("unsel_src", 2'd0, 32'h1);

`ifdef DMA_IRQ_EN
        // Interrupt follows DONE by one cycle
        reg_wr(2'd3, 32'h14);
        check_reg("ie_ctrl", 2'd3, 32'h10);
        check("irq_low", {31'd0, irq}, 32'd0);
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'h240);
        reg_wr(2'd2, 32'd1);
        reg_wr(2'd3, 32'h11);
        repeat (2) @(negedge clk);
        check("irq_at_done", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
        reg_wr(2'd3, 32'h14);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
`else
        // IE is absent: bit 4 reads zero
        reg_wr(2'd3, 32'h14);
        check_reg("no_ie_ctrl", 2'd3, 32'h0);
`endif

        // Reset in the middle of a stalled read
        stall = 5;
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'h250);
        reg_wr(2'd2, 32'd3);
        reg_wr(2'd3, 32'h1);
        check("mid_rd_active", {31'd0, avm_read}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        check("mid_rst_addr", {2'b0, avm_addr}, 32'd0);
        rst_n = 1'b1;
        stall = 0;
        check_reg("mid_rst_src", 2'd0, 32'd0);
        check_reg("mid_rst_dst", 2'd1, 32'd0);
        check_reg("mid_rst_len", 2'd2, 32'd0);
        check_reg("mid_rst_ctrl", 2'd3, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_quiet", {30'd0, avm_read, avm_write}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
